// File: rtl/teller_dispatch.sv
// -----------------------------------------------------------------------------
// teller_dispatch
//
// Teller-side counterpart to the bank queue manager. Whenever the queue is
// non-empty and an enabled teller is idle, the lowest-index such teller is
// called. The block then emits a one-cycle sensor_end pulse toward the queue
// counter and times that teller's service.
//
// Parameters
//   SERVICE_CYCLES  cycles a teller stays busy per customer (1..255)
//   SERVED_W        width of the served-customer counter
//
// Ports
//   clk            system clock, rising edge
//   RESET          asynchronous active-high reset
//   Tellers_count  number of enabled tellers (teller k enabled when k <= count)
//   Empty_flag     queue counter reads zero
//   teller_done    bit k-1: one-cycle early-release pulse from teller k
//   sensor_end     one-cycle pulse: a customer has left the queue
//   call_teller    index (1..3) of the most recently called teller, 0 before any
//   busy           bit k-1 high while teller k is serving
//   served_count   customers dispatched since reset, wraps
// -----------------------------------------------------------------------------
module teller_dispatch #(
  parameter int unsigned SERVICE_CYCLES = 8,
  parameter int unsigned SERVED_W       = 8
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic [1:0]          Tellers_count,
  input  logic                Empty_flag,
  input  logic [2:0]          teller_done,
  output logic                sensor_end,
  output logic [1:0]          call_teller,
  output logic [2:0]          busy,
  output logic [SERVED_W-1:0] served_count
);

  localparam int unsigned NUM_TELLERS = 3;
  localparam logic [7:0]  TIMER_LOAD  = 8'(SERVICE_CYCLES - 1);

  logic [NUM_TELLERS-1:0][7:0] timer;
  logic [NUM_TELLERS-1:0][7:0] timer_nxt;
  logic [NUM_TELLERS-1:0]      busy_nxt;
  logic [NUM_TELLERS-1:0]      enabled;
  logic [NUM_TELLERS-1:0]      eligible;
  logic [NUM_TELLERS-1:0]      grant;
  logic                        dispatch;
  logic                        sensor_end_nxt;
  logic [1:0]                  call_teller_nxt;
  logic [SERVED_W-1:0]         served_count_nxt;

  // Eligibility and lowest-index priority grant, all from registered state so
  // a teller freeing on this edge is only eligible from the next edge on.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch; a path
    // that leaves one unassigned would infer a latch.
    enabled  = '0;
    eligible = '0;
    grant    = '0;
    for (int k = 0; k < NUM_TELLERS; k++) begin
      enabled[k]  = (Tellers_count >= 2'(k + 1));
      eligible[k] = enabled[k] && !busy[k];
    end
    for (int k = 0; k < NUM_TELLERS; k++) begin
      if (eligible[k] && (grant == '0)) grant[k] = 1'b1;
    end
    // sensor_end still high means the queue counter has not yet had a cycle
    // to update Empty_flag, so hold off one edge.
    dispatch = !Empty_flag && !sensor_end && (eligible != '0);
  end

  // Next-state for per-teller service timers, pulse and bookkeeping.
  always_comb begin
    busy_nxt         = busy;
    timer_nxt        = timer;
    sensor_end_nxt   = 1'b0;
    call_teller_nxt  = call_teller;
    served_count_nxt = served_count;

    // A serving teller finishes on early release or when its timer reaches 0;
    // teller_done on an idle teller falls through untouched.
    for (int k = 0; k < NUM_TELLERS; k++) begin
      if (busy[k]) begin
        if (teller_done[k] || (timer[k] == 8'd0)) busy_nxt[k] = 1'b0;
        else                                      timer_nxt[k] = timer[k] - 8'd1;
      end
    end

    // A granted teller is idle, so this never collides with the release above.
    if (dispatch) begin
      sensor_end_nxt   = 1'b1;
      served_count_nxt = served_count + SERVED_W'(1);
      for (int k = 0; k < NUM_TELLERS; k++) begin
        if (grant[k]) begin
          busy_nxt[k]     = 1'b1;
          timer_nxt[k]    = TIMER_LOAD;
          call_teller_nxt = 2'(k + 1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the timers are a small register array, not a RAM, so they are reset
  // along with everything else; in-flight services vanish on RESET.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sensor_end   <= 1'b0;
      call_teller  <= 2'd0;
      busy         <= '0;
      timer        <= '0;
      served_count <= '0;
    end else begin
      sensor_end   <= sensor_end_nxt;
      call_teller  <= call_teller_nxt;
      busy         <= busy_nxt;
      timer        <= timer_nxt;
      served_count <= served_count_nxt;
    end
  end

endmodule
